imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction-memory path: receives a program as a big-endian byte stream over a valid/ready handshake, packs it into 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the multi-cycle core stalled (core_run low) until the load completes, then releases it.
- Sits between the host/byte source and the instruction memory that the fetch stage reads.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that arms a load.
- in_valid  in  1  byte source has in_data valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  assembled instruction word.
- core_run  out  1  core may fetch/execute; high only in DONE.
- load_done  out  1  load finished successfully; level, high in DONE.
- load_err  out  1  load aborted; level, high in ERR.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 instruction bytes, MSB first.
- A byte transfers on a rising clk edge where in_valid && in_ready.
- States:
  - IDLE: start → LEN_HI.
  - LEN_HI: byte → LEN_LO.
  - LEN_LO: byte → DATA if 0 < N ≤ 2^ADDR_W; DONE if N = 0; ERR if N > 2^ADDR_W.
  - DATA: accept 4 bytes → WRITE.
  - WRITE: 1 cycle, imem_we=1 with imem_addr=words_loaded[ADDR_W-1:0] and imem_wdata=assembled word. On the following edge words_loaded increments; → DATA if words_loaded+1 < N, else DONE.
  - DONE: start → LEN_HI.
  - ERR: start → LEN_HI.
- in_ready is 1 in LEN_HI, LEN_LO, DATA (and CSUM); 0 in IDLE, WRITE, DONE, ERR.
- Throughput: 1 word per 5 cycles with in_valid held high.
- Byte lane: 1st data byte → wdata[31:24]; 4th → wdata[7:0].
- start is ignored in LEN_HI, LEN_LO, DATA, WRITE and CSUM.
- On re-arm from DONE/ERR:
  - core_run, load_done and load_err drop on the same edge the state leaves.
  - words_loaded clears to 0.
  - byte counter and word register clear.
- imem_wdata and imem_addr hold their last value when imem_we=0.
- Reset values (any time, including mid-load): state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_run=0, load_done=0, load_err=0, words_loaded=0, internal byte counter=0. Memory contents already written are not cleared.
- N = 2^ADDR_W: last write goes to the all-ones address; words_loaded reaches 2^ADDR_W without wrap (hence the ADDR_W+1 width).
- in_valid while in_ready=0 is not consumed; the source must hold the byte.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of every accepted byte, including LEN_HI and LEN_LO, is cleared on arm.
  - After the final WRITE (or after LEN_LO when N=0), state CSUM accepts one trailing byte.
  - Trailing byte equal to the running XOR → DONE; otherwise → ERR.
- Undefined: no CSUM state and no checksum logic; the final WRITE goes directly to DONE.

Decomposition:
- Add to the shared definitions file (definations.v):
  - loader state encodings `LD_IDLE, `LD_LEN_HI, `LD_LEN_LO, `LD_DATA, `LD_WRITE, `LD_CSUM, `LD_DONE, `LD_ERR, each 3 bits.
  - `LD_BYTES_PER_WORD = 4.
- One natural sub-module, word_packer:
  - 2-bit byte counter, 32-bit shift register and word_full flag.
  - clear input driven by the loader on arm and on reset.

Test Plan:
- Reset then start, stream 00 02 24 08 00 05 AC 09 00 04 → two writes: addr0=0x24080005, addr1=0xAC090004; words_loaded=2; load_done=1 and core_run=1 in the cycle after the 2nd write.
- N=0 (00 00) → DONE with no imem_we pulse; words_loaded=0.
- ADDR_W=8, N=0x0101 → ERR after LEN_LO; load_err=1; in_ready=0; no write. A new start re-arms and a valid 1-word load then succeeds.
- in_valid toggled randomly mid-word → bytes consumed only on handshake; wdata identical to the back-to-back case; in_ready=0 during each WRITE.
- Assert rst_n low during the 3rd byte of word 1 → all outputs 0 asynchronously. After release and start, a full 1-word load writes addr0.
- With LOADER_CHECKSUM_EN, stream 00 01 12 34 56 78 plus trailing byte 0x09 → DONE (XOR of the six bytes = 0x09). Trailing byte 0x08 → ERR, core_run stays 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encodings and packing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
        StCsum  = 3'd5,
        StDone  = 3'd6,
        StErr   = 3'd7
    } ld_state_e;

    localparam int unsigned LdBytesPerWord = 4;

    function automatic logic accepts_byte(input ld_state_e st);
        return (st == StLenHi) || (st == StLenLo) || (st == StData) || (st == StCsum);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; first byte lands in bits [31:24].
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    assign word_next = {word_q[23:0], byte_in};
    // Asserted on the byte that completes the word, so the caller can latch word_next directly.
    assign word_full = shift_en && (cnt_q == 2'(LdBytesPerWord - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clear) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (shift_en) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the core until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned Cap = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] WordOne = 1;

    // Where the load goes once the last word (or an empty program) is written.
    localparam ld_state_e StFinal =
`ifdef LOADER_CHECKSUM_EN
        StCsum;
`else
        StDone;
`endif

    ld_state_e   state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] len_n;
    logic        accept;
    logic        arm;
    logic        pk_shift;
    logic        pk_full;
    logic [31:0] pk_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept   = in_valid && in_ready;
    assign arm      = start && ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    assign len_n    = {len_q[15:8], in_data};
    assign pk_shift = accept && (state_q == StData);

    imem_loader_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (arm),
        .shift_en  (pk_shift),
        .byte_in   (in_data),
        .word_next (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StLenHi;
            end
            StLenHi: begin
                if (accept) state_d = StLenLo;
            end
            StLenLo: begin
                if (accept) begin
                    if (len_n == 16'd0)            state_d = StFinal;
                    else if (32'(len_n) > Cap)     state_d = StErr;
                    else                           state_d = StData;
                end
            end
            StData: begin
                if (pk_full) state_d = StWrite;
            end
            StWrite: begin
                if (32'(words_loaded) + 32'd1 < 32'(len_q)) state_d = StData;
                else                                         state_d = StFinal;
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            in_ready  <= 1'b0;
            imem_we   <= 1'b0;
            core_run  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= accepts_byte(state_d);
            imem_we   <= (state_d == StWrite);
            core_run  <= (state_d == StDone);
            load_done <= (state_d == StDone);
            load_err  <= (state_d == StErr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= 16'd0;
            words_loaded <= '0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
        end else begin
            if (arm) words_loaded <= '0;
            if (accept && (state_q == StLenHi)) len_q <= {in_data, len_q[7:0]};
            if (accept && (state_q == StLenLo)) len_q <= len_n;
            if (pk_full) begin
                imem_addr  <= words_loaded[ADDR_W-1:0];
                imem_wdata <= pk_word;
            end
            if (state_q == StWrite) words_loaded <= words_loaded + WordOne;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // The trailing checksum byte itself is not folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'd0;
        end else if (arm) begin
            csum_q <= 8'd0;
        end else if (accept && (state_q != StCsum)) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

endmodule
